// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 transmit datapath.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;

  typedef logic [7:0] rc4_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_KSA,
    ST_READY
  } rc4_state_t;

endpackage

// File: rtl/rc4_sbox_regs.sv
// 256x8 RC4 state array: two combinational read ports, single-cycle swap write,
// and a keystream read that returns the post-swap value of S[S[a]+S[b]].
module rc4_sbox_regs
  import rc4_pkg::*;
(
  input  logic      clk,
  input  logic      init_en,
  input  logic      swap_en,
  input  rc4_byte_t addr_a,
  input  rc4_byte_t addr_b,
  output rc4_byte_t rd_a,
  output rc4_byte_t rd_b,
  output rc4_byte_t ks
);

  rc4_byte_t s_mem [SBOX_SIZE];
  rc4_byte_t t_idx;

  assign rd_a  = s_mem[addr_a];
  assign rd_b  = s_mem[addr_b];
  assign t_idx = rd_a + rd_b;

  // The swap lands at the clock edge, so entries it touches are forwarded.
  always_comb begin
    ks = s_mem[t_idx];
    if (t_idx == addr_a) begin
      ks = rd_b;
    end else if (t_idx == addr_b) begin
      ks = rd_a;
    end
  end

  always_ff @(posedge clk) begin
    if (init_en) begin
      for (int n = 0; n < SBOX_SIZE; n++) begin
        s_mem[n] <= rc4_byte_t'(n);
      end
    end else if (swap_en) begin
      s_mem[addr_a] <= rd_b;
      s_mem[addr_b] <= rd_a;
    end
  end

endmodule

// File: rtl/rc4_encrypt.sv
// RC4 encryptor: key byte-stream in, KSA over the register S-box, then one
// PRGA step per accepted plaintext byte into a registered ciphertext stage.
module rc4_encrypt
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_byte,
  input  logic       key_valid,
  input  logic       key_last,
  output logic       init_done,
  input  logic [7:0] pt_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  output logic [7:0] ct_data,
  output logic       ct_valid,
  input  logic       ct_ready,
  output rc4_state_t dbg_state
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int LW = KW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(KEY_LEN);

  rc4_state_t      state_q, state_d;
  rc4_byte_t       i_q, j_q;
  logic [LW-1:0]   len_q;
  logic [KW-1:0]   kidx_q;
  rc4_byte_t       key_mem [2**KW];
  rc4_byte_t       ct_data_q;
  logic            ct_valid_q;

  rc4_byte_t       addr_a, jn, rd_a, rd_b, ks, key_sel;
  logic            key_take, init_en, swap_en, pt_ready_c, pt_accept;
  logic            key_wr_en, kidx_last;
  logic [KW-1:0]   key_wr_idx;

  assign key_sel   = key_mem[kidx_q];
  assign kidx_last = ({1'b0, kidx_q} == (len_q - LW'(1)));
  assign addr_a    = (state_q == ST_READY) ? (i_q + 8'd1) : i_q;
  assign jn        = j_q + rd_a + ((state_q == ST_KSA) ? key_sel : 8'd0);

  rc4_sbox_regs u_sbox (
    .clk     (clk),
    .init_en (init_en),
    .swap_en (swap_en),
    .addr_a  (addr_a),
    .addr_b  (jn),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .ks      (ks)
  );

  // Plaintext handshake: a byte moves when pt_valid && pt_ready at a clock edge;
  // pt_ready never looks at pt_valid, and a key byte in READY takes priority.
  // Ciphertext handshake: ct_data is held while ct_valid && !ct_ready.
  always_comb begin
    state_d    = state_q;
    key_take   = 1'b0;
    init_en    = 1'b0;
    swap_en    = 1'b0;
    pt_ready_c = 1'b0;
    pt_accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_valid) begin
          key_take = 1'b1;
          state_d  = key_last ? ST_INIT : ST_LOAD;
        end else if (state_q == ST_READY) begin
          pt_ready_c = !ct_valid_q || ct_ready;
          pt_accept  = pt_valid && pt_ready_c;
          swap_en    = pt_accept;
        end
      end
      ST_LOAD: begin
        if (key_valid) begin
          key_take = 1'b1;
          if (key_last) state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        init_en = 1'b1;
        state_d = ST_KSA;
      end
      ST_KSA: begin
        swap_en = 1'b1;
        if (i_q == 8'hFF) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_wr_en  = key_take && ((state_q != ST_LOAD) || (len_q < LEN_MAX));
  assign key_wr_idx = (state_q == ST_LOAD) ? len_q[KW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (key_wr_en) key_mem[key_wr_idx] <= key_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      len_q      <= '0;
      kidx_q     <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (key_take) begin
        if (state_q == ST_LOAD) begin
          if (len_q < LEN_MAX) len_q <= len_q + LW'(1);
        end else begin
          len_q <= LW'(1);
        end
      end
      case (state_q)
        ST_INIT: begin
          i_q    <= '0;
          j_q    <= '0;
          kidx_q <= '0;
        end
        ST_KSA: begin
          i_q    <= i_q + 8'd1;
          j_q    <= (i_q == 8'hFF) ? 8'd0 : jn;
          kidx_q <= kidx_last ? '0 : kidx_q + KW'(1);
        end
        ST_READY: begin
          if (pt_accept) begin
            i_q <= addr_a;
            j_q <= jn;
          end
        end
        default: ;
      endcase
      if (pt_accept) begin
        ct_data_q  <= pt_data ^ ks;
        ct_valid_q <= 1'b1;
      end else if (ct_ready) begin
        ct_valid_q <= 1'b0;
      end
    end
  end

  assign init_done = (state_q == ST_READY);
  assign pt_ready  = pt_ready_c;
  assign ct_data   = ct_data_q;
  assign ct_valid  = ct_valid_q;
  assign dbg_state = state_q;

endmodule
